bcd_time_counter: RTL and testbench

Time-of-day keeper for the alarm clock: divides the system clock to a 1 s tick and maintains hours, minutes and seconds as packed BCD. It sits directly upstream of the seven-segment display driver; `o_BCD_Num` connects straight to that driver's `i_BCD_Num` as HH:MM. A set mode lets the user adjust hours and minutes from debounced buttons.

---
 rtl/alarm_clock_pkg.sv | 11 +
 rtl/bcd_mod_counter.sv | 26 ++
 rtl/bcd_time_counter.sv | 61 ++++++
 tb/tb_bcd_time_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: BCD widths, digit limits and packed HH:MM field positions shared across the alarm clock
package alarm_clock_pkg;
  localparam int BCD_W = 4;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HOUR_MAX = 23;
  localparam int HOUR_TENS_LSB = 12;
  localparam int HOUR_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 0;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping from MAX to 00
// ports: i_Clk/i_Reset clock and sync reset; i_Inc advance by one; i_Clear force 00;
//        o_Value packed {tens, ones}; o_Carry high when i_Inc arrives at MAX
module bcd_mod_counter
  import alarm_clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Inc,
  input  logic       i_Clear,
  output logic [7:0] o_Value,
  output logic       o_Carry
);
  localparam logic [7:0] MAX_BCD = {4'(MAX / 10), 4'(MAX % 10)};
  logic [7:0] next;
  assign o_Carry = i_Inc && (o_Value == MAX_BCD);
  // per-digit increment: ones 9 rolls to 0 and bumps tens
  assign next = o_Carry ? 8'h00
              : o_Value[BCD_W-1:0] == 4'd9 ? {o_Value[7:BCD_W] + 4'd1, 4'd0}
              : {o_Value[7:BCD_W], o_Value[BCD_W-1:0] + 4'd1};
  always_ff @(posedge i_Clk)
    if (i_Reset || i_Clear) o_Value <= 8'h00;
    else if (i_Inc) o_Value <= next;
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 s prescaler plus BCD hh:mm:ss time keeper with button set mode
// ports: i_Clk/i_Reset clock and sync reset; i_Set_Mode high = set time;
//        i_Inc_Hour/i_Inc_Min debounced buttons (rising edge counts in set mode);
//        o_BCD_Num {HH,MM}; o_Seconds_BCD {SS}; o_Sec_Tick/o_Min_Tick one-cycle pulses
module bcd_time_counter
  import alarm_clock_pkg::*;
#(
  parameter int CLK_IN = 5000000,
  parameter int SEC_DIV = CLK_IN
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Set_Mode,
  input  logic        i_Inc_Hour,
  input  logic        i_Inc_Min,
  output logic [15:0] o_BCD_Num,
  output logic [7:0]  o_Seconds_BCD,
  output logic        o_Sec_Tick,
  output logic        o_Min_Tick
);
  localparam int CW = $clog2(SEC_DIV);
  logic [CW-1:0] cnt;
  logic prev_hour, prev_min;
  logic terminal, sec_inc, min_inc, hour_inc, sec_carry, min_carry, hour_carry;
  logic [7:0] min_val, hour_val;
  assign terminal = cnt == CW'(SEC_DIV - 1);
  assign sec_inc = !i_Set_Mode && terminal;
  // set mode bypasses the seconds chain and never lets minutes carry into hours
  assign min_inc = i_Set_Mode ? i_Inc_Min && !prev_min : sec_carry;
  assign hour_inc = i_Set_Mode ? i_Inc_Hour && !prev_hour : min_carry;
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      cnt <= '0;
      prev_hour <= 1'b0;
      prev_min <= 1'b0;
      o_Sec_Tick <= 1'b0;
      o_Min_Tick <= 1'b0;
    end else begin
      cnt <= (i_Set_Mode || terminal) ? '0 : cnt + 1'b1;
      prev_hour <= i_Inc_Hour;
      prev_min <= i_Inc_Min;
      o_Sec_Tick <= sec_inc;
      o_Min_Tick <= sec_carry;
    end
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Inc(sec_inc), .i_Clear(i_Set_Mode),
    .o_Value(o_Seconds_BCD), .o_Carry(sec_carry)
  );
  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Inc(min_inc), .i_Clear(1'b0),
    .o_Value(min_val), .o_Carry(min_carry)
  );
  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Inc(hour_inc), .i_Clear(1'b0),
    .o_Value(hour_val), .o_Carry(hour_carry)
  );
  assign o_BCD_Num[HOUR_TENS_LSB+BCD_W-1:HOUR_ONES_LSB] = hour_val;
  assign o_BCD_Num[MIN_TENS_LSB+BCD_W-1:MIN_ONES_LSB] = min_val;
  logic unused;
  assign unused = hour_carry;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed checks of the BCD time counter with a 5-cycle second
module tb_bcd_time_counter;
  logic clk = 1'b0, rst = 1'b1, set = 1'b0, inc_hour = 1'b0, inc_min = 1'b0;
  logic [15:0] bcd;
  logic [7:0] sec;
  logic sec_tick, min_tick;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  bcd_time_counter #(.SEC_DIV(5)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Set_Mode(set), .i_Inc_Hour(inc_hour), .i_Inc_Min(inc_min),
    .o_BCD_Num(bcd), .o_Seconds_BCD(sec), .o_Sec_Tick(sec_tick), .o_Min_Tick(min_tick)
  );
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; set = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
    step(1);
    rst = 1'b0;
  endtask
  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hour = 1'b1; step(1); inc_hour = 1'b0; step(1);
    end
  endtask
  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; step(1); inc_min = 1'b0; step(1);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h exp 0000", bcd); end
    checks++; if (sec !== 8'h00) begin errors++; $display("FAIL reset_sec got %h exp 00", sec); end
    checks++; if ({sec_tick, min_tick} !== 2'b00) begin errors++; $display("FAIL reset_ticks got %b exp 00", {sec_tick, min_tick}); end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL early_tick cycle %0d got %b exp 0", i, sec_tick); end
    end
    step(1);
    checks++; if (sec_tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b exp 1", sec_tick); end
    checks++; if (sec !== 8'h01) begin errors++; $display("FAIL first_sec got %h exp 01", sec); end
  endtask
  task automatic test_run_minute();
    int st = 0, mt = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1);
      st += int'(sec_tick); mt += int'(min_tick);
    end
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL run_bcd got %h exp 0001", bcd); end
    checks++; if (sec !== 8'h00) begin errors++; $display("FAIL run_sec got %h exp 00", sec); end
    checks++; if (st != 60) begin errors++; $display("FAIL run_sec_ticks got %0d exp 60", st); end
    checks++; if (mt != 1) begin errors++; $display("FAIL run_min_ticks got %0d exp 1", mt); end
  endtask
  task automatic test_set_wrap();
    int mt = 0, st = 0;
    do_reset();
    set = 1'b1;
    step(1);
    pulse_hour(23);
    pulse_min(59);
    checks++; if (bcd !== 16'h2359) begin errors++; $display("FAIL set_2359 got %h exp 2359", bcd); end
    checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL set_no_tick got %b exp 0", sec_tick); end
    set = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      mt += int'(min_tick); st += int'(sec_tick);
    end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL day_wrap got %h exp 0000", bcd); end
    checks++; if (sec !== 8'h00) begin errors++; $display("FAIL day_wrap_sec got %h exp 00", sec); end
    checks++; if (mt != 1) begin errors++; $display("FAIL day_wrap_min_ticks got %0d exp 1", mt); end
    checks++; if (st != 60) begin errors++; $display("FAIL day_wrap_sec_ticks got %0d exp 60", st); end
  endtask
  task automatic test_hold_and_run_edges();
    do_reset();
    set = 1'b1;
    step(1);
    inc_min = 1'b1;
    step(10);
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL hold_min got %h exp 0001", bcd); end
    inc_min = 1'b0;
    step(1);
    set = 1'b0;
    inc_hour = 1'b1; inc_min = 1'b1;
    step(2);
    inc_hour = 1'b0; inc_min = 1'b0;
    step(1);
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL run_edges got %h exp 0001", bcd); end
    inc_hour = 1'b1;
    step(1);
    set = 1'b1;
    step(2);
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL not_queued got %h exp 0001", bcd); end
    inc_hour = 1'b0;
    step(1);
  endtask
  task automatic test_simultaneous();
    do_reset();
    set = 1'b1;
    step(1);
    pulse_hour(9);
    pulse_min(59);
    checks++; if (bcd !== 16'h0959) begin errors++; $display("FAIL pre_0959 got %h exp 0959", bcd); end
    inc_hour = 1'b1; inc_min = 1'b1;
    step(1);
    checks++; if (bcd !== 16'h1000) begin errors++; $display("FAIL both_edges got %h exp 1000", bcd); end
    inc_hour = 1'b0; inc_min = 1'b0;
    step(1);
  endtask
  task automatic test_set_suppress();
    do_reset();
    step(4);
    set = 1'b1;
    step(1);
    checks++; if (sec !== 8'h00) begin errors++; $display("FAIL suppress_sec got %h exp 00", sec); end
    checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL suppress_tick got %b exp 0", sec_tick); end
    set = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL exit_early_tick cycle %0d got %b exp 0", i, sec_tick); end
    end
    step(1);
    checks++; if (sec_tick !== 1'b1 || sec !== 8'h01) begin errors++; $display("FAIL exit_first_tick got %b/%h exp 1/01", sec_tick, sec); end
  endtask
  task automatic test_reset_midrun();
    do_reset();
    set = 1'b1;
    step(1);
    pulse_hour(12);
    pulse_min(34);
    set = 1'b0;
    step(280);
    checks++; if ({bcd, sec} !== 24'h123456) begin errors++; $display("FAIL midrun got %h exp 123456", {bcd, sec}); end
    rst = 1'b1;
    step(1);
    checks++; if ({bcd, sec} !== 24'h000000) begin errors++; $display("FAIL midrun_reset got %h exp 000000", {bcd, sec}); end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL post_reset_early cycle %0d got %b exp 0", i, sec_tick); end
    end
    step(1);
    checks++; if (sec_tick !== 1'b1 || sec !== 8'h01) begin errors++; $display("FAIL post_reset_tick got %b/%h exp 1/01", sec_tick, sec); end
  endtask
  initial begin
    test_reset();
    test_run_minute();
    test_set_wrap();
    test_hold_and_run_edges();
    test_simultaneous();
    test_set_suppress();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
